// File: rtl/pipeline_ctrl_pkg.sv
`default_nettype none
// ============================================================================
// Module  : pipeline_ctrl_pkg
// Brief   : Shared types for the LC-3b pipeline stall/flush sequencer.
// Revision: 1.0 - initial release
// ============================================================================
package pipeline_ctrl_pkg;

    // RUN: normal operation. IND2: second (pointer-dereference) access of LDI/STI.
    typedef enum logic [0:0] {
        RUN  = 1'b0,
        IND2 = 1'b1
    } pipe_ctrl_state_t;

    localparam int c_REG_NUM_W = 3;

endpackage
`default_nettype wire

// File: rtl/pipeline_ctrl_hazard_detect.sv
`default_nettype none
// ============================================================================
// Module  : pipeline_ctrl_hazard_detect
// Brief   : Load-use register-number compare between id_ex and decode.
// Revision: 1.0 - initial release
// ============================================================================
module pipeline_ctrl_hazard_detect
    import pipeline_ctrl_pkg::*;
(
    input  logic                   id_ex_valid,
    input  logic                   id_ex_is_load,
    input  logic [c_REG_NUM_W-1:0] id_ex_dest,
    input  logic [c_REG_NUM_W-1:0] id_sr1_num,
    input  logic [c_REG_NUM_W-1:0] id_sr2_num,
    input  logic                   id_uses_sr1,
    input  logic                   id_uses_sr2,
    output logic                   hazard
);

    logic w_sr1_hit;
    logic w_sr2_hit;

    // A decode source that reads the register a pending load will write must wait one cycle.
    always_comb begin
        w_sr1_hit = id_uses_sr1 && (id_sr1_num == id_ex_dest);
        w_sr2_hit = id_uses_sr2 && (id_sr2_num == id_ex_dest);
        hazard    = id_ex_valid && id_ex_is_load && (w_sr1_hit || w_sr2_hit);
    end

endmodule
`default_nettype wire

// File: rtl/pipeline_ctrl.sv
`default_nettype none
// ============================================================================
// Module  : pipeline_ctrl
// Brief   : Stall/flush sequencer for the 5-stage LC-3b pipeline, with
//           LDI/STI two-access sequencing and a saturating stall counter.
// Revision: 1.0 - initial release
// ============================================================================
module pipeline_ctrl
    import pipeline_ctrl_pkg::*;
#(
    parameter int CNT_WIDTH = 16
) (
    input  logic                 clk,
    input  logic                 reset,
    input  logic                 imem_req,
    input  logic                 imem_resp,
    input  logic                 dmem_req,
    input  logic                 dmem_resp,
    input  logic                 mem_indirect,
    input  logic                 redirect,
    input  logic                 id_ex_valid,
    input  logic                 id_ex_is_load,
    input  logic [2:0]           id_ex_dest,
    input  logic [2:0]           id_sr1_num,
    input  logic [2:0]           id_sr2_num,
    input  logic                 id_uses_sr1,
    input  logic                 id_uses_sr2,
    output logic                 load_pc,
    output logic                 load_if_id,
    output logic                 load_id_ex,
    output logic                 load_ex_mem,
    output logic                 load_mem_wb,
    output logic                 flush_if_id,
    output logic                 flush_id_ex,
    output logic                 flush_ex_mem,
    output logic                 mem_ind_phase,
    output logic [CNT_WIDTH-1:0] stall_count
);

    localparam logic [CNT_WIDTH-1:0] c_CNT_ONE = {{(CNT_WIDTH-1){1'b0}}, 1'b1};
    localparam logic [CNT_WIDTH-1:0] c_CNT_MAX = {CNT_WIDTH{1'b1}};

    pipe_ctrl_state_t       state_q, state_d;
    logic                   ind_done_q, ind_done_d;
    logic [CNT_WIDTH-1:0]   stall_count_q, stall_count_d;

    logic w_hazard;
    logic w_imem_stall;
    logic w_dmem_stall;
    logic w_g_stall;
    logic w_ind_resp;

    pipeline_ctrl_hazard_detect u_hazard_detect (
        .id_ex_valid   (id_ex_valid),
        .id_ex_is_load (id_ex_is_load),
        .id_ex_dest    (id_ex_dest),
        .id_sr1_num    (id_sr1_num),
        .id_sr2_num    (id_sr2_num),
        .id_uses_sr1   (id_uses_sr1),
        .id_uses_sr2   (id_uses_sr2),
        .hazard        (w_hazard)
    );

    // Stall detection, prioritised enables/flushes, and next-state/counter logic.
    always_comb begin
        // Second access counts as complete once its response has been seen,
        // even if the fetch side is still stalled and holds us in IND2.
        w_ind_resp   = dmem_resp || ind_done_q;
        w_imem_stall = imem_req && !imem_resp;
        if (state_q == IND2) begin
            w_dmem_stall = !w_ind_resp;
        end else begin
            w_dmem_stall = dmem_req && (!dmem_resp || mem_indirect);
        end
        w_g_stall = w_imem_stall || w_dmem_stall;

        load_pc       = 1'b1;
        load_if_id    = 1'b1;
        load_id_ex    = 1'b1;
        load_ex_mem   = 1'b1;
        load_mem_wb   = 1'b1;
        flush_if_id   = 1'b0;
        flush_id_ex   = 1'b0;
        flush_ex_mem  = 1'b0;
        mem_ind_phase = (state_q == IND2);
        state_d       = state_q;
        ind_done_d    = ind_done_q;
        stall_count_d = stall_count_q;

        if (reset) begin
            flush_if_id   = 1'b1;
            flush_id_ex   = 1'b1;
            flush_ex_mem  = 1'b1;
            mem_ind_phase = 1'b0;
            state_d       = RUN;
            ind_done_d    = 1'b0;
            stall_count_d = '0;
        end else begin
            if (w_g_stall) begin
                load_pc     = 1'b0;
                load_if_id  = 1'b0;
                load_id_ex  = 1'b0;
                load_ex_mem = 1'b0;
                load_mem_wb = 1'b0;
            end else if (redirect) begin
                flush_if_id  = 1'b1;
                flush_id_ex  = 1'b1;
                flush_ex_mem = 1'b1;
            end else if (w_hazard) begin
                load_pc     = 1'b0;
                load_if_id  = 1'b0;
                flush_id_ex = 1'b1;
            end

            if ((w_g_stall || (!redirect && w_hazard)) && (stall_count_q != c_CNT_MAX)) begin
                stall_count_d = stall_count_q + c_CNT_ONE;
            end

            if (state_q == RUN) begin
                if (dmem_req && mem_indirect && dmem_resp) begin
                    state_d    = IND2;
                    ind_done_d = 1'b0;
                end
            end else if (w_ind_resp) begin
                if (w_imem_stall) begin
                    ind_done_d = 1'b1;
                end else begin
                    state_d    = RUN;
                    ind_done_d = 1'b0;
                end
            end
        end
    end

    // State, indirect-done flag and stall counter registers.
    always_ff @(posedge clk) begin
        state_q       <= state_d;
        ind_done_q    <= ind_done_d;
        stall_count_q <= stall_count_d;
    end

    assign stall_count = stall_count_q;

endmodule
`default_nettype wire

// File: tb/tb_pipeline_ctrl.sv
`default_nettype none
// ============================================================================
// Module  : tb_pipeline_ctrl
// Brief   : Self-checking bench for pipeline_ctrl (CNT_WIDTH = 4).
// Revision: 1.0 - initial release
// ============================================================================
module tb_pipeline_ctrl;

    localparam int c_CW = 4;

    typedef struct packed {
        logic       imem_req;
        logic       imem_resp;
        logic       dmem_req;
        logic       dmem_resp;
        logic       mem_ind;
        logic       redirect;
        logic       v;
        logic       ld;
        logic [2:0] dest;
        logic [2:0] sr1;
        logic [2:0] sr2;
        logic       u1;
        logic       u2;
    } vin_t;

    typedef struct packed {
        vin_t       in;
        logic [7:0] exp;
    } vec_t;

    // Control bundle order: load_pc,if_id,id_ex,ex_mem,mem_wb, flush_if_id,id_ex,ex_mem
    localparam logic [7:0] c_ADV = 8'b11111_000;
    localparam logic [7:0] c_FRZ = 8'b00000_000;
    localparam logic [7:0] c_ALL = 8'b11111_111;
    localparam logic [7:0] c_HAZ = 8'b00111_010;

    logic clk = 1'b0;
    logic rst_i = 1'b1;
    vin_t vin = '0;

    logic lpc, lifid, lidex, lexmem, lmemwb, fifid, fidex, fexmem, phase;
    logic [c_CW-1:0] cnt;
    logic [7:0] ctrl;

    int total = 0;
    int bad = 0;

    // Reference model state (abstract: "in second access", "second access done", count)
    bit m_ind;
    bit m_done;
    int m_cnt;

    always #5 clk = ~clk;

    pipeline_ctrl #(.CNT_WIDTH(c_CW)) dut (
        .clk           (clk),
        .reset         (rst_i),
        .imem_req      (vin.imem_req),
        .imem_resp     (vin.imem_resp),
        .dmem_req      (vin.dmem_req),
        .dmem_resp     (vin.dmem_resp),
        .mem_indirect  (vin.mem_ind),
        .redirect      (vin.redirect),
        .id_ex_valid   (vin.v),
        .id_ex_is_load (vin.ld),
        .id_ex_dest    (vin.dest),
        .id_sr1_num    (vin.sr1),
        .id_sr2_num    (vin.sr2),
        .id_uses_sr1   (vin.u1),
        .id_uses_sr2   (vin.u2),
        .load_pc       (lpc),
        .load_if_id    (lifid),
        .load_id_ex    (lidex),
        .load_ex_mem   (lexmem),
        .load_mem_wb   (lmemwb),
        .flush_if_id   (fifid),
        .flush_id_ex   (fidex),
        .flush_ex_mem  (fexmem),
        .mem_ind_phase (phase),
        .stall_count   (cnt)
    );

    assign ctrl = {lpc, lifid, lidex, lexmem, lmemwb, fifid, fidex, fexmem};

    task automatic check(input string name, input int got, input int exp);
        total++;
        if (got != exp) begin
            bad++;
            $display("FAIL %s: got=%0h expected=%0h at %0t", name, got, exp, $time);
        end
    endtask

    // Expected control bundle from the priority rules.
    function automatic logic [7:0] model_ctrl(input vin_t v, input logic r, output bit stalled);
        bit ist, dst, haz;
        ist = v.imem_req && !v.imem_resp;
        if (m_ind) dst = !(v.dmem_resp || m_done);
        else       dst = v.dmem_req && (!v.dmem_resp || v.mem_ind);
        haz = v.v && v.ld && ((v.u1 && v.sr1 == v.dest) || (v.u2 && v.sr2 == v.dest));
        stalled = 1'b0;
        if (r) return c_ALL;
        if (ist || dst) begin stalled = 1'b1; return c_FRZ; end
        if (v.redirect) return c_ALL;
        if (haz) begin stalled = 1'b1; return c_HAZ; end
        return c_ADV;
    endfunction

    // One clock: drive, check against model, advance model over the coming edge.
    task automatic step(input vin_t v, input logic r, input string tag);
        logic [7:0] e;
        bit st, ist;
        @(negedge clk);
        vin = v;
        rst_i = r;
        #1;
        e = model_ctrl(v, r, st);
        check({tag, ".ctrl"}, ctrl, e);
        check({tag, ".phase"}, phase, (m_ind && !r) ? 1 : 0);
        check({tag, ".cnt"}, cnt, m_cnt);
        ist = v.imem_req && !v.imem_resp;
        if (r) begin
            m_ind = 0; m_done = 0; m_cnt = 0;
        end else begin
            if (st && m_cnt < (1 << c_CW) - 1) m_cnt++;
            if (!m_ind) begin
                if (v.dmem_req && v.mem_ind && v.dmem_resp) begin m_ind = 1; m_done = 0; end
            end else if (v.dmem_resp || m_done) begin
                if (ist) m_done = 1;
                else begin m_ind = 0; m_done = 0; end
            end
        end
    endtask

    function automatic vin_t idle();
        vin_t v = '0;
        v.imem_req = 1; v.imem_resp = 1;
        return v;
    endfunction

    vec_t tbl[13];

    initial begin
        vin_t v;
        // ---- table of single-cycle behaviours from RUN ----
        v = idle();                                                  tbl[0] = '{v, c_ADV};
        v = idle(); v.imem_resp = 0;                                 tbl[1] = '{v, c_FRZ};
        v = idle(); v.dmem_req = 1;                                  tbl[2] = '{v, c_FRZ};
        v = idle(); v.dmem_req = 1; v.dmem_resp = 1;                 tbl[3] = '{v, c_ADV};
        v = idle(); v.v = 1; v.ld = 1; v.dest = 3; v.sr2 = 3; v.u2 = 1; v.sr1 = 3; tbl[4] = '{v, c_HAZ};
        v = idle(); v.v = 1; v.ld = 1; v.dest = 3; v.sr1 = 3; v.sr2 = 5; v.u2 = 1; tbl[5] = '{v, c_ADV};
        v = idle(); v.ld = 1; v.dest = 3; v.sr2 = 3; v.u2 = 1;       tbl[6] = '{v, c_ADV};
        v = idle(); v.v = 1; v.dest = 3; v.sr2 = 3; v.u2 = 1;        tbl[7] = '{v, c_ADV};
        v = idle(); v.v = 1; v.ld = 1; v.dest = 3; v.sr2 = 3; v.u2 = 1; v.redirect = 1; tbl[8] = '{v, c_ALL};
        v = idle(); v.dmem_req = 1; v.redirect = 1;                  tbl[9] = '{v, c_FRZ};
        v = idle(); v.imem_resp = 0; v.redirect = 1;                 tbl[10] = '{v, c_FRZ};
        v = idle(); v.imem_resp = 0; v.v = 1; v.ld = 1; v.dest = 6; v.sr1 = 6; v.u1 = 1; tbl[11] = '{v, c_FRZ};
        v = idle(); v.v = 1; v.ld = 1; v.dest = 6; v.sr1 = 6; v.u1 = 1; tbl[12] = '{v, c_HAZ};

        step(idle(), 1'b1, "reset");
        for (int i = 0; i < 13; i++) begin
            step(tbl[i].in, 1'b0, $sformatf("tbl%0d", i));
            check($sformatf("tbl%0d.exp", i), ctrl, tbl[i].exp);
        end

        // ---- hit stream: counter stays at zero ----
        step(idle(), 1'b1, "rst_hit");
        for (int i = 0; i < 5; i++) step(idle(), 1'b0, "hit");
        check("hit.cnt0", cnt, 0);

        // ---- 3-cycle fetch miss ----
        v = idle(); v.imem_resp = 0;
        for (int i = 0; i < 3; i++) step(v, 1'b0, "imiss");
        step(idle(), 1'b0, "imiss_adv");
        check("imiss.adv", ctrl, c_ADV);
        check("imiss.cnt3", cnt, 3);

        // ---- LDI, responses at cycles 2 and 5 ----
        step(idle(), 1'b1, "rst_ldi");
        for (int c = 0; c < 6; c++) begin
            v = idle(); v.dmem_req = 1; v.mem_ind = 1; v.dmem_resp = (c == 2 || c == 5);
            step(v, 1'b0, $sformatf("ldi%0d", c));
            check($sformatf("ldi%0d.phase", c), phase, (c >= 3) ? 1 : 0);
            check($sformatf("ldi%0d.ctrl", c), ctrl, (c == 5) ? c_ADV : c_FRZ);
        end
        step(idle(), 1'b0, "ldi_run");
        check("ldi.back_run", phase, 0);

        // ---- LDI aborted by reset in IND2 ----
        for (int c = 0; c < 4; c++) begin
            v = idle(); v.dmem_req = 1; v.mem_ind = 1; v.dmem_resp = (c == 2);
            step(v, c == 3, $sformatf("ldia%0d", c));
        end
        step(idle(), 1'b0, "ldia_after");
        check("ldia.phase0", phase, 0);

        // ---- second access completes while fetch is stalled ----
        v = idle(); v.dmem_req = 1; v.mem_ind = 1; v.dmem_resp = 1;
        step(v, 1'b0, "ind_a");
        v.imem_resp = 0;
        step(v, 1'b0, "ind_b");
        v.dmem_resp = 0;
        step(v, 1'b0, "ind_c");
        check("ind.held", phase, 1);
        v.imem_resp = 1;
        step(v, 1'b0, "ind_d");
        check("ind.release", ctrl, c_ADV);
        step(idle(), 1'b0, "ind_e");
        check("ind.run", phase, 0);

        // ---- redirect during data stall: flush on response ----
        v = idle(); v.dmem_req = 1; v.redirect = 1;
        step(v, 1'b0, "rd_stall");
        v.dmem_resp = 1;
        step(v, 1'b0, "rd_resp");
        check("rd.flush", ctrl, c_ALL);

        // ---- saturation: 2^4 + 5 stalled cycles ----
        step(idle(), 1'b1, "rst_sat");
        v = idle(); v.imem_resp = 0;
        for (int i = 0; i < 21; i++) step(v, 1'b0, "sat");
        step(idle(), 1'b0, "sat_end");
        check("sat.cnt15", cnt, 15);

        // ---- randomized against the model ----
        for (int i = 0; i < 3000; i++) begin
            v.imem_req  = ($urandom_range(0, 9) != 0);
            v.imem_resp = ($urandom_range(0, 3) != 0);
            v.dmem_req  = ($urandom_range(0, 2) == 0);
            v.dmem_resp = ($urandom_range(0, 1) == 0);
            v.mem_ind   = ($urandom_range(0, 3) == 0);
            v.redirect  = ($urandom_range(0, 7) == 0);
            v.v         = $urandom_range(0, 1);
            v.ld        = $urandom_range(0, 1);
            v.dest      = 3'($urandom_range(0, 7));
            v.sr1       = 3'($urandom_range(0, 7));
            v.sr2       = 3'($urandom_range(0, 7));
            v.u1        = $urandom_range(0, 1);
            v.u2        = $urandom_range(0, 1);
            step(v, ($urandom_range(0, 59) == 0), "rnd");
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/pipeline_ctrl.md
Name: pipeline_ctrl

Overview:
Central stall/flush sequencer for the 5-stage LC-3b pipeline. It generates the load enables for the PC and for the if_id, id_ex, ex_mem and mem_wb registers, and the bubble-insert (flush) selects for those registers. It handles instruction- and data-memory wait states, the two-access LDI/STI sequence, load-use hazards and taken-branch/JMP/TRAP redirects. It also keeps a saturating stall-cycle counter for performance measurement.

Parameters:
CNT_WIDTH, 16, width of stall_count

Ports:
clk  in  1  system clock, all state updates on rising edge
reset  in  1  synchronous, active-high reset
imem_req  in  1  fetch stage is requesting an instruction
imem_resp  in  1  instruction memory returns data this cycle
dmem_req  in  1  mem stage holds a valid load/store
dmem_resp  in  1  data memory completes the access this cycle
mem_indirect  in  1  mem-stage instruction is LDI or STI
redirect  in  1  mem stage resolved a PC change (pc mux select non-zero)
id_ex_valid  in  1  id_ex holds a real instruction (not a bubble)
id_ex_is_load  in  1  id_ex instruction writes a register from memory (LDR/LDB/LDI)
id_ex_dest  in  3  destination register number in id_ex
id_sr1_num  in  3  decode-stage SR1 number
id_sr2_num  in  3  decode-stage SR2 number
id_uses_sr1  in  1  decode instruction reads SR1
id_uses_sr2  in  1  decode instruction reads SR2
load_pc  out  1  PC register enable
load_if_id  out  1  if_id enable
load_id_ex  out  1  id_ex enable
load_ex_mem  out  1  ex_mem enable
load_mem_wb  out  1  mem_wb enable
flush_if_id  out  1  insert bubble into if_id
flush_id_ex  out  1  zero control word/dest into id_ex
flush_ex_mem  out  1  zero control word into ex_mem
mem_ind_phase  out  1  1 = second LDI/STI access; address is taken from MDR
stall_count  out  CNT_WIDTH  saturating count of stalled cycles

Behaviour:
- States: RUN, IND2. Registered state, stall_count and ind_done flag. All other outputs are combinational from state and inputs.
- Reset cycle:
  - All load_* = 1 and all flush_* = 1, so the pipeline registers fill with bubbles.
  - mem_ind_phase = 0.
  - Next state = RUN, stall_count <= 0.
  - Memory responses are ignored. Reset in IND2 aborts the indirect access.
- imem_stall = imem_req & ~imem_resp.
- dmem_stall:
  - In RUN: dmem_req & (~dmem_resp | mem_indirect).
  - In IND2: ~dmem_resp.
- g_stall = imem_stall | dmem_stall. When g_stall is high, all load_* = 0 and all flush_* = 0. The whole pipeline freezes; no partial advance.
- RUN -> IND2: when dmem_req & mem_indirect & dmem_resp. The first access is complete, the pipeline stays frozen that cycle, and the MDR captures the pointer.
- IND2:
  - mem_ind_phase = 1.
  - On dmem_resp, go to RUN; the pipeline advances that same cycle, provided imem_stall = 0.
  - If imem_stall = 1, stay in IND2 with ind_done set and do not re-issue the access.
  - Leave IND2 on the first cycle with ~imem_stall & ind_done.
- Redirect (g_stall = 0, redirect = 1):
  - All load_* = 1.
  - flush_if_id = flush_id_ex = flush_ex_mem = 1.
  - The mem-stage instruction itself proceeds to mem_wb.
- Load-use (g_stall = 0, redirect = 0): hazard = id_ex_valid & id_ex_is_load & ((id_uses_sr1 & id_sr1_num == id_ex_dest) | (id_uses_sr2 & id_sr2_num == id_ex_dest)).
  - If hazard: load_pc = load_if_id = 0, load_id_ex = 1 with flush_id_ex = 1, ex_mem and mem_wb load.
  - Exactly one bubble is inserted; the next cycle id_ex is invalid, so the hazard clears.
- Priority: reset > g_stall > redirect > load-use > normal.
- Normal advance: all load_* = 1, flush_* = 0.
- stall_count: increments on any cycle with g_stall or hazard-stall (not redirect). It saturates at all-ones, never wraps.

Decomposition:
- lc3b_types gains the pipe_ctrl_state enum (RUN, IND2).
- One combinational sub-module, hazard_detect: register-number compare producing hazard. It is reusable for future forwarding logic.

Test Plan:
- Hit-every-cycle stream (imem_resp = 1, no dmem_req) -> all load_* = 1 every cycle, flush_* = 0, stall_count stays 0.
- imem_req with imem_resp low for 3 cycles -> all load_* = 0 for 3 cycles, advance on the 4th, stall_count = 3.
- LDI: dmem_req + mem_indirect, resp at cycles 2 and 5 -> frozen cycles 0-4, mem_ind_phase = 1 cycles 3-5, advance at cycle 5, back to RUN. Repeat with reset asserted at cycle 3 -> state RUN, mem_ind_phase = 0 the next cycle.
- LDR R3 in id_ex, ADD using SR2 = R3 in decode -> one cycle with load_pc = load_if_id = 0 and flush_id_ex = 1, then normal flow; SR1 = R3 with id_uses_sr1 = 0 -> no stall.
- redirect coincident with load-use hazard -> flush_if_id/id_ex/ex_mem = 1, all loads = 1; redirect coincident with dmem_stall -> freeze only; the flush happens on the cycle dmem_resp arrives.
- Force stall for 2^CNT_WIDTH + 5 cycles (CNT_WIDTH = 4) -> stall_count holds 15.
